// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// master = requester/consumer side, slave = the adder sequencer.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one shared full adder, one bit per clock, LSB first,
// with valid/ready handshakes on operand entry and result exit.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave io
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             carry_out_q;
    logic             overflow_q;
    logic             accept;
    logic             msb_cycle;
    logic             fa_a;
    logic             fa_b;
    logic             fa_s;
    logic             fa_co;

    // The single full adder shared by every bit position.
    always_comb begin
        fa_a  = a_sh[0];
        fa_b  = b_sh[0];
        fa_s  = fa_a ^ fa_b ^ carry;
        fa_co = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));
    end

    assign res_nx    = {fa_s, res[WIDTH-1:1]};
    assign msb_cycle = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.busy      = 1'b0;
        unique case (state)
            IDLE: begin
                io.in_ready = 1'b1;
                accept      = io.in_valid;
                if (io.in_valid) state_nx = RUN;
            end
            RUN: begin
                io.busy = 1'b1;
                if (msb_cycle) state_nx = DONE;
            end
            DONE: begin
                io.out_valid = 1'b1;
                if (io.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            res         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_sh  <= io.a;
                b_sh  <= io.sub ? ~io.b : io.b;
                carry <= io.sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                res   <= res_nx;
                carry <= fa_co;
                cnt   <= cnt + CNT_W'(1);
                if (msb_cycle) begin
                    sum_q       <= res_nx;
                    carry_out_q <= fa_co;
                    overflow_q  <= carry ^ fa_co;
                end
            end
        end
    end

    assign io.sum       = sum_q;
    assign io.carry_out = carry_out_q;
    assign io.overflow  = overflow_q;
endmodule
